// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared PacketStream types and helpers
package ps_pkg;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } ps_limiter_state_t;

    // A MAXLEN of 1 still needs a 1-bit word counter to keep widths legal
    function automatic int wcnt_width(input int maxlen);
        return (maxlen > 1) ? $clog2(maxlen) : 1;
    endfunction

endpackage

// File: rtl/ps_pkt_limiter_if.sv
// rtl/ps_pkt_limiter_if.sv - PacketStream word interface
interface ps_pkt_limiter_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] dat;
    logic              val;
    logic              eop;
    logic              rdy;

    modport master (output dat, output val, output eop, input rdy);
    modport slave  (input dat, input val, input eop, output rdy);

endinterface

// File: rtl/ps_skid_buffer.sv
// rtl/ps_skid_buffer.sv - 2-entry valid/ready register slice with registered ready
module ps_skid_buffer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] up_dat,
    input  logic             up_val,
    output logic             up_rdy,
    output logic [WIDTH-1:0] dn_dat,
    output logic             dn_val,
    input  logic             dn_rdy
);

    logic [WIDTH-1:0] main_dat, main_dat_n;
    logic [WIDTH-1:0] skid_dat, skid_dat_n;
    logic             main_val, main_val_n;
    logic             skid_val, skid_val_n;
    logic             accept;
    logic             load;

    always_comb begin
        accept     = up_val & up_rdy;
        load       = ~main_val | dn_rdy;
        main_dat_n = main_dat;
        main_val_n = main_val;
        skid_dat_n = skid_dat;
        skid_val_n = skid_val;
        if (load) begin
            // up_rdy is low whenever the skid entry holds a word
            if (skid_val) begin
                main_dat_n = skid_dat;
                main_val_n = 1'b1;
                skid_val_n = 1'b0;
            end else begin
                main_val_n = accept;
                if (accept) begin
                    main_dat_n = up_dat;
                end
            end
        end else if (accept) begin
            skid_dat_n = up_dat;
            skid_val_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_dat <= '0;
            main_val <= 1'b0;
            skid_dat <= '0;
            skid_val <= 1'b0;
            up_rdy   <= 1'b0;
        end else begin
            main_dat <= main_dat_n;
            main_val <= main_val_n;
            skid_dat <= skid_dat_n;
            skid_val <= skid_val_n;
            up_rdy   <= ~skid_val_n;
        end
    end

    assign dn_dat = main_dat;
    assign dn_val = main_val;

endmodule

// File: rtl/ps_pkt_limiter.sv
// rtl/ps_pkt_limiter.sv - truncates packets longer than MAXLEN words, counts truncations
module ps_pkt_limiter
    import ps_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int MAXLEN = 256,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    ps_pkt_limiter_if.slave   i,
    ps_pkt_limiter_if.master  o,
    output logic              o_trunc,
    output logic [CWIDTH-1:0] trunc_cnt
);

    localparam int             WCW   = wcnt_width(MAXLEN);
    localparam logic [WCW-1:0] WLAST = WCW'(MAXLEN - 1);

    ps_limiter_state_t state, state_n;
    logic [WCW-1:0]    wcnt, wcnt_n;
    logic              accept;
    logic              at_limit;
    logic              trunc_ev;
    logic              skid_rdy;

    // Dropping must never stall on output backpressure
    assign i.rdy    = (state == DROP) | skid_rdy;
    assign accept   = i.val & i.rdy;
    assign at_limit = (wcnt == WLAST);

    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        trunc_ev = 1'b0;
        case (state)
            PASS: begin
                if (accept) begin
                    if (i.eop) begin
                        wcnt_n = '0;
                    end else if (at_limit) begin
                        wcnt_n   = '0;
                        trunc_ev = 1'b1;
                        state_n  = DROP;
                    end else begin
                        wcnt_n = wcnt + 1'b1;
                    end
                end
            end
            DROP: begin
                if (accept && i.eop) begin
                    state_n = PASS;
                end
            end
            default: state_n = PASS;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PASS;
            wcnt      <= '0;
            o_trunc   <= 1'b0;
            trunc_cnt <= '0;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            o_trunc <= trunc_ev;
            if (trunc_ev && (trunc_cnt != '1)) begin
                trunc_cnt <= trunc_cnt + 1'b1;
            end
        end
    end

    ps_skid_buffer #(
        .WIDTH (DWIDTH + 1)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .up_dat ({i.eop | at_limit, i.dat}),
        .up_val (i.val & (state == PASS)),
        .up_rdy (skid_rdy),
        .dn_dat ({o.eop, o.dat}),
        .dn_val (o.val),
        .dn_rdy (o.rdy)
    );

endmodule

// File: tb/tb_ps_pkt_limiter.sv
// tb/tb_ps_pkt_limiter.sv - directed self-checking bench for ps_pkt_limiter
module tb_ps_pkt_limiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trunc_a, trunc_b;
    logic [1:0]  cnt_a;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses_a = 0;
    int viol_b = 0;
    logic        pend_b = 1'b0;
    logic [8:0]  prev_b = '0;
    logic [8:0]  qa[$];
    logic [8:0]  qb[$];
    int          stamp_b[$];

    always #5 clk = ~clk;

    ps_pkt_limiter_if #(.DWIDTH(8)) ia ();
    ps_pkt_limiter_if #(.DWIDTH(8)) oa ();
    ps_pkt_limiter_if #(.DWIDTH(8)) ib ();
    ps_pkt_limiter_if #(.DWIDTH(8)) ob ();

    ps_pkt_limiter #(.DWIDTH(8), .MAXLEN(4), .CWIDTH(2)) dut_a (
        .clk(clk), .reset(reset), .i(ia), .o(oa), .o_trunc(trunc_a), .trunc_cnt(cnt_a)
    );

    ps_pkt_limiter #(.DWIDTH(8), .MAXLEN(256), .CWIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .i(ib), .o(ob), .o_trunc(trunc_b), .trunc_cnt(cnt_b)
    );

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (oa.val && oa.rdy) qa.push_back({oa.eop, oa.dat});
            if (trunc_a) pulses_a++;
            if (ob.val && ob.rdy) begin
                qb.push_back({ob.eop, ob.dat});
                stamp_b.push_back(cyc);
            end
            if (pend_b && !(ob.val && ({ob.eop, ob.dat} == prev_b))) viol_b++;
            pend_b = ob.val && !ob.rdy;
            prev_b = {ob.eop, ob.dat};
        end else begin
            pend_b = 1'b0;
        end
    end

    task automatic send_a(input logic [7:0] d, input logic e, output int waited);
        ia.dat = d; ia.eop = e; ia.val = 1'b1; waited = 0;
        forever begin
            @(negedge clk);
            if (ia.rdy || waited >= 50) break;
            waited++;
        end
        @(posedge clk); #1;
        ia.val = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic e, input bit rnd, output int waited);
        ib.dat = d; ib.eop = e; ib.val = 1'b1; waited = 0;
        forever begin
            @(negedge clk);
            if (ib.rdy || waited >= 50) break;
            waited++;
            @(posedge clk); #1;
            if (rnd) ob.rdy = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        if (rnd) ob.rdy = 1'($urandom_range(0, 1));
        ib.val = 1'b0;
    endtask

    task automatic drain_a(input int n);
        int t = 0;
        while (qa.size() < n && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic drain_b(input int n, input bit rnd);
        int t = 0;
        while (qb.size() < n && t < 400) begin
            @(posedge clk); #1;
            if (rnd) ob.rdy = 1'($urandom_range(0, 1));
            @(negedge clk); t++;
        end
        @(posedge clk); #1;
        ob.rdy = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; ia.val = 1'b0; ib.val = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        qa.delete(); qb.delete(); stamp_b.delete(); pulses_a = 0; viol_b = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (oa.val !== 1'b0) begin errors++; $display("FAIL rst_oval got %b exp 0", oa.val); end
        checks++; if (oa.eop !== 1'b0) begin errors++; $display("FAIL rst_oeop got %b exp 0", oa.eop); end
        checks++; if (oa.dat !== 8'h00) begin errors++; $display("FAIL rst_odat got %h exp 00", oa.dat); end
        checks++; if (trunc_a !== 1'b0) begin errors++; $display("FAIL rst_trunc got %b exp 0", trunc_a); end
        checks++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", cnt_a); end
        checks++; if (ia.rdy !== 1'b0) begin errors++; $display("FAIL rst_irdy got %b exp 0", ia.rdy); end
        @(posedge clk); #1 reset = 1'b0;
        #2;
        checks++; if (ia.rdy !== 1'b0) begin errors++; $display("FAIL rel_irdy_pre got %b exp 0", ia.rdy); end
        @(posedge clk); #1;
        checks++; if (ia.rdy !== 1'b1) begin errors++; $display("FAIL rel_irdy_post got %b exp 1", ia.rdy); end
        checks++; if (ib.rdy !== 1'b1) begin errors++; $display("FAIL rel_irdy_b got %b exp 1", ib.rdy); end
    endtask

    task automatic test_short();
        int w;
        logic [8:0] exp_q[$];
        exp_q = '{9'h0A1, 9'h0A2, 9'h1A3};
        qa.delete(); pulses_a = 0;
        send_a(8'hA1, 1'b0, w);
        checks++; if (oa.val !== 1'b1 || oa.dat !== 8'hA1) begin errors++; $display("FAIL latency got val=%b dat=%h exp val=1 dat=a1", oa.val, oa.dat); end
        send_a(8'hA2, 1'b0, w);
        send_a(8'hA3, 1'b1, w);
        drain_a(3);
        checks++; if (qa.size() !== 3) begin errors++; $display("FAIL short_count got %0d exp 3", qa.size()); end
        for (int k = 0; k < 3 && k < qa.size(); k++) begin
            checks++; if (qa[k] !== exp_q[k]) begin errors++; $display("FAIL short_word%0d got %h exp %h", k, qa[k], exp_q[k]); end
        end
        checks++; if (pulses_a !== 0) begin errors++; $display("FAIL short_pulses got %0d exp 0", pulses_a); end
        checks++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL short_cnt got %0d exp 0", cnt_a); end
    endtask

    task automatic test_exact();
        int w;
        qa.delete(); pulses_a = 0;
        for (int k = 0; k < 4; k++) send_a(8'(8'h30 + k), k == 3, w);
        drain_a(4);
        checks++; if (qa.size() !== 4) begin errors++; $display("FAIL exact_count got %0d exp 4", qa.size()); end
        for (int k = 0; k < 4 && k < qa.size(); k++) begin
            checks++; if (qa[k] !== {k == 3, 8'(8'h30 + k)}) begin errors++; $display("FAIL exact_word%0d got %h exp %h", k, qa[k], {k == 3, 8'(8'h30 + k)}); end
        end
        checks++; if (pulses_a !== 0) begin errors++; $display("FAIL exact_pulses got %0d exp 0", pulses_a); end
        checks++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL exact_cnt got %0d exp 0", cnt_a); end
    endtask

    task automatic test_trunc();
        int w;
        logic [8:0] exp_q[$];
        exp_q = '{9'h010, 9'h011, 9'h012, 9'h113, 9'h020, 9'h121};
        qa.delete(); pulses_a = 0;
        for (int k = 0; k < 7; k++) begin
            send_a(8'(8'h10 + k), k == 6, w);
            if (k == 3) begin
                checks++; if (trunc_a !== 1'b1) begin errors++; $display("FAIL trunc_pulse got %b exp 1", trunc_a); end
                checks++; if ({oa.val, oa.eop, oa.dat} !== 10'h313) begin errors++; $display("FAIL trunc_forced_eop got %h exp 313", {oa.val, oa.eop, oa.dat}); end
                checks++; if (cnt_a !== 2'd1) begin errors++; $display("FAIL trunc_cnt_upd got %0d exp 1", cnt_a); end
            end
            if (k >= 4) begin
                checks++; if (w !== 0) begin errors++; $display("FAIL drop_irdy_w%0d waited %0d exp 0", k, w); end
                checks++; if (oa.val !== 1'b0) begin errors++; $display("FAIL drop_oval_w%0d got %b exp 0", k, oa.val); end
            end
        end
        send_a(8'h20, 1'b0, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL drop_to_pass waited %0d exp 0", w); end
        send_a(8'h21, 1'b1, w);
        drain_a(6);
        checks++; if (qa.size() !== 6) begin errors++; $display("FAIL trunc_count got %0d exp 6", qa.size()); end
        for (int k = 0; k < 6 && k < qa.size(); k++) begin
            checks++; if (qa[k] !== exp_q[k]) begin errors++; $display("FAIL trunc_word%0d got %h exp %h", k, qa[k], exp_q[k]); end
        end
        checks++; if (pulses_a !== 1) begin errors++; $display("FAIL trunc_pulses got %0d exp 1", pulses_a); end
        checks++; if (cnt_a !== 2'd1) begin errors++; $display("FAIL trunc_cnt got %0d exp 1", cnt_a); end
    endtask

    task automatic test_backpressure();
        int w;
        qa.delete();
        oa.rdy = 1'b0;
        send_a(8'h60, 1'b0, w);
        send_a(8'h61, 1'b0, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL skid_second waited %0d exp 0", w); end
        checks++; if (ia.rdy !== 1'b0) begin errors++; $display("FAIL skid_full_irdy got %b exp 0", ia.rdy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({oa.val, oa.eop, oa.dat} !== 10'h260) begin errors++; $display("FAIL stall_hold got %h exp 260", {oa.val, oa.eop, oa.dat}); end
        oa.rdy = 1'b1;
        send_a(8'h62, 1'b1, w);
        drain_a(3);
        checks++; if (qa.size() !== 3) begin errors++; $display("FAIL bp_count got %0d exp 3", qa.size()); end
        for (int k = 0; k < 3 && k < qa.size(); k++) begin
            checks++; if (qa[k] !== {k == 2, 8'(8'h60 + k)}) begin errors++; $display("FAIL bp_word%0d got %h exp %h", k, qa[k], {k == 2, 8'(8'h60 + k)}); end
        end
    endtask

    task automatic test_reset_in_drop();
        int w;
        do_reset();
        for (int k = 0; k < 6; k++) send_a(8'(8'h50 + k), 1'b0, w);
        checks++; if (cnt_a !== 2'd1) begin errors++; $display("FAIL pre_reset_cnt got %0d exp 1", cnt_a); end
        #2 reset = 1'b1;
        #1;
        checks++; if (oa.val !== 1'b0) begin errors++; $display("FAIL async_rst_oval got %b exp 0", oa.val); end
        checks++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL async_rst_cnt got %0d exp 0", cnt_a); end
        checks++; if (ia.rdy !== 1'b0) begin errors++; $display("FAIL async_rst_irdy got %b exp 0", ia.rdy); end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        qa.delete(); pulses_a = 0;
        for (int k = 0; k < 3; k++) send_a(8'(8'h40 + k), k == 2, w);
        drain_a(3);
        checks++; if (qa.size() !== 3) begin errors++; $display("FAIL rdrop_count got %0d exp 3", qa.size()); end
        for (int k = 0; k < 3 && k < qa.size(); k++) begin
            checks++; if (qa[k] !== {k == 2, 8'(8'h40 + k)}) begin errors++; $display("FAIL rdrop_word%0d got %h exp %h", k, qa[k], {k == 2, 8'(8'h40 + k)}); end
        end
        checks++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL rdrop_cnt got %0d exp 0", cnt_a); end
    endtask

    task automatic test_saturate();
        int w;
        int exp_cnt[5];
        exp_cnt = '{1, 2, 3, 3, 3};
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 6; k++) send_a(8'(p * 16 + k), k == 5, w);
            checks++; if (int'(cnt_a) !== exp_cnt[p]) begin errors++; $display("FAIL sat_cnt_p%0d got %0d exp %0d", p, cnt_a, exp_cnt[p]); end
        end
        drain_a(20);
        checks++; if (pulses_a !== 5) begin errors++; $display("FAIL sat_pulses got %0d exp 5", pulses_a); end
        checks++; if (qa.size() !== 20) begin errors++; $display("FAIL sat_count got %0d exp 20", qa.size()); end
        for (int j = 0; j < 20 && j < qa.size(); j++) begin
            checks++; if (qa[j] !== {(j % 4) == 3, 8'((j / 4) * 16 + (j % 4))}) begin errors++; $display("FAIL sat_word%0d got %h exp %h", j, qa[j], {(j % 4) == 3, 8'((j / 4) * 16 + (j % 4))}); end
        end
    endtask

    task automatic test_throughput();
        int w;
        int total = 0;
        qb.delete(); stamp_b.delete();
        ob.rdy = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 10; k++) begin
                send_b(8'(p * 10 + k), k == 9, 1'b0, w);
                total += w;
            end
        drain_b(20, 1'b0);
        checks++; if (total !== 0) begin errors++; $display("FAIL tput_stalls got %0d exp 0", total); end
        checks++; if (qb.size() !== 20) begin errors++; $display("FAIL tput_count got %0d exp 20", qb.size()); end
        if (stamp_b.size() == 20) begin
            checks++; if (stamp_b[19] - stamp_b[0] !== 19) begin errors++; $display("FAIL tput_span got %0d exp 19", stamp_b[19] - stamp_b[0]); end
        end
        for (int j = 0; j < 20 && j < qb.size(); j++) begin
            checks++; if (qb[j] !== {(j % 10) == 9, 8'(j)}) begin errors++; $display("FAIL tput_word%0d got %h exp %h", j, qb[j], {(j % 10) == 9, 8'(j)}); end
        end
    endtask

    task automatic test_back_to_back();
        int w;
        qb.delete(); viol_b = 0;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 10; k++) send_b(8'(8'h80 + p * 10 + k), k == 9, 1'b1, w);
        drain_b(40, 1'b1);
        checks++; if (qb.size() !== 40) begin errors++; $display("FAIL b2b_count got %0d exp 40", qb.size()); end
        for (int j = 0; j < 40 && j < qb.size(); j++) begin
            checks++; if (qb[j] !== {(j % 10) == 9, 8'(8'h80 + j)}) begin errors++; $display("FAIL b2b_word%0d got %h exp %h", j, qb[j], {(j % 10) == 9, 8'(8'h80 + j)}); end
        end
        checks++; if (viol_b !== 0) begin errors++; $display("FAIL b2b_stall_stability got %0d exp 0", viol_b); end
        checks++; if (cnt_b !== 16'd0) begin errors++; $display("FAIL b2b_cnt got %0d exp 0", cnt_b); end
    endtask

    initial begin
        ia.val = 1'b0; ia.dat = '0; ia.eop = 1'b0; oa.rdy = 1'b1;
        ib.val = 1'b0; ib.dat = '0; ib.eop = 1'b0; ob.rdy = 1'b1;
        test_reset();
        test_short();
        test_exact();
        test_trunc();
        test_backpressure();
        test_reset_in_drop();
        test_saturate();
        test_throughput();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
